// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one integer ALU among NumReq requesters, with a one-entry response register.
// Optional feature: define ALU_ARB_STALL_CNT_EN to add the stall_cnt_o counter and stall_clr_i input.

package alu_arbiter_pkg;
  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_BRANCH,
    ALUOP_FUNCT
  } aluop_e;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int Xlen   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [NumReq*3-1:0]    req_funct3_i,
  input  logic [NumReq*7-1:0]    req_funct7_i,
  input  logic [NumReq-1:0]      req_itype_i,
  input  aluop_e [NumReq-1:0]    req_aluop_i,
  input  logic [NumReq*Xlen-1:0] req_a_i,
  input  logic [NumReq*Xlen-1:0] req_b_i,
  output logic [2:0]             alu_funct3_o,
  output logic [6:0]             alu_funct7_o,
  output logic                   alu_itype_o,
  output aluop_e                 alu_aluop_o,
  output logic [Xlen-1:0]        alu_a_o,
  output logic [Xlen-1:0]        alu_b_o,
  input  logic [Xlen-1:0]        alu_res_i,
  input  logic                   alu_zero_i,
  output logic [NumReq-1:0]      resp_valid_o,
  input  logic [NumReq-1:0]      resp_ready_i,
  output logic [Xlen-1:0]        resp_res_o,
`ifdef ALU_ARB_STALL_CNT_EN
  output logic                   resp_zero_o,
  input  logic                   stall_clr_i,
  output logic [31:0]            stall_cnt_o
`else
  output logic                   resp_zero_o
`endif
);

  localparam int RespIdW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  state_e               state_q, state_d;
  logic [RespIdW-1:0]   owner_q, owner_d;
  logic [RespIdW-1:0]   ptr_q, ptr_d;
  logic [Xlen-1:0]      res_q, res_d;
  logic                 zero_q, zero_d;
  logic [RespIdW-1:0]   gnt_idx;
  logic [RespIdW-1:0]   cand;
  logic                 gnt_valid;
  logic                 resp_fire;
  logic                 can_accept;
  logic                 accept;

  // Search starts at the pointer and wraps, so the last winner has lowest priority.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = RespIdW'((int'(ptr_q) + i) % NumReq);
      if (!gnt_valid && req_valid_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign resp_fire  = (state_q == FULL) && resp_ready_i[owner_q];
  assign can_accept = (state_q == EMPTY) || resp_fire;
  assign accept     = gnt_valid && can_accept && rst_ni;

  assign req_ready_o  = accept ? (NumReq'(1) << gnt_idx) : '0;
  assign resp_valid_o = (state_q == FULL) ? (NumReq'(1) << owner_q) : '0;
  assign resp_res_o   = res_q;
  assign resp_zero_o  = zero_q;

  assign alu_funct3_o = req_funct3_i[int'(gnt_idx)*3 +: 3];
  assign alu_funct7_o = req_funct7_i[int'(gnt_idx)*7 +: 7];
  assign alu_itype_o  = req_itype_i[gnt_idx];
  assign alu_aluop_o  = req_aluop_i[gnt_idx];
  assign alu_a_o      = req_a_i[int'(gnt_idx)*Xlen +: Xlen];
  assign alu_b_o      = req_b_i[int'(gnt_idx)*Xlen +: Xlen];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    res_d   = res_q;
    zero_d  = zero_q;
    if (accept) begin
      state_d = FULL;
      owner_d = gnt_idx;
      ptr_d   = (int'(gnt_idx) == NumReq - 1) ? '0 : RespIdW'(int'(gnt_idx) + 1);
      res_d   = alu_res_i;
      zero_d  = alu_zero_i;
    end else if (resp_fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      owner_q <= '0;
      ptr_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

`ifdef ALU_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // A stall is any cycle with pending requests that accepts nothing; clear wins.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr_i) begin
      stall_cnt_d = '0;
    end else if (|req_valid_i && !accept) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU on the alu_* side, scoreboard of expected responses
// pushed as requests are offered and popped whenever a response handshake completes.

module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic clk;
   logic rstN;
   logic [1:0] reqValid;
   logic [1:0] reqReady;
   logic [5:0] reqFunct3;
   logic [13:0] reqFunct7;
   logic [1:0] reqItype;
   aluop_e [1:0] reqAluop;
   logic [63:0] reqA;
   logic [63:0] reqB;
   logic [2:0] aluFunct3;
   logic [6:0] aluFunct7;
   logic aluItype;
   aluop_e aluAluop;
   logic [31:0] aluA;
   logic [31:0] aluB;
   logic [31:0] aluRes;
   logic aluZero;
   logic [1:0] respValid;
   logic [1:0] respReady;
   logic [31:0] respRes;
   logic respZero;
`ifdef ALU_ARB_STALL_CNT_EN
   logic stallClr;
   logic [31:0] stallCnt;
`endif

   typedef struct {
      int          owner;
      logic [31:0] res;
      logic        zero;
   } expT;

   expT sbQ[$];
   int compared = 0;
   int mismatched = 0;
   logic [31:0] aVal [2];
   logic [31:0] bVal [2];

   alu_arbiter #(.NumReq(2), .Xlen(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .req_valid_i  (reqValid),
      .req_ready_o  (reqReady),
      .req_funct3_i (reqFunct3),
      .req_funct7_i (reqFunct7),
      .req_itype_i  (reqItype),
      .req_aluop_i  (reqAluop),
      .req_a_i      (reqA),
      .req_b_i      (reqB),
      .alu_funct3_o (aluFunct3),
      .alu_funct7_o (aluFunct7),
      .alu_itype_o  (aluItype),
      .alu_aluop_o  (aluAluop),
      .alu_a_o      (aluA),
      .alu_b_o      (aluB),
      .alu_res_i    (aluRes),
      .alu_zero_i   (aluZero),
      .resp_valid_o (respValid),
      .resp_ready_i (respReady),
      .resp_res_o   (respRes),
`ifdef ALU_ARB_STALL_CNT_EN
      .resp_zero_o  (respZero),
      .stall_clr_i  (stallClr),
      .stall_cnt_o  (stallCnt)
`else
      .resp_zero_o  (respZero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: branch ops report "taken" on the zero flag, everything else reports result==0.
   always_comb begin
      aluRes = 32'd0;
      aluZero = 1'b0;
      case (aluAluop)
         ALUOP_ADD: begin
            aluRes = aluA + aluB;
            aluZero = (aluRes == 32'd0);
         end
         ALUOP_BRANCH: begin
            aluRes = aluA - aluB;
            case (aluFunct3)
               3'd0: aluZero = (aluA == aluB);
               3'd1: aluZero = (aluA != aluB);
               3'd4: aluZero = ($signed(aluA) < $signed(aluB));
               3'd5: aluZero = ($signed(aluA) >= $signed(aluB));
               3'd6: aluZero = (aluA < aluB);
               3'd7: aluZero = (aluA >= aluB);
               default: aluZero = 1'b0;
            endcase
         end
         default: begin
            case (aluFunct3)
               3'd0: aluRes = (!aluItype && aluFunct7[5]) ? aluA - aluB : aluA + aluB;
               3'd4: aluRes = aluA ^ aluB;
               3'd6: aluRes = aluA | aluB;
               3'd7: aluRes = aluA & aluB;
               default: aluRes = aluA + aluB;
            endcase
            aluZero = (aluRes == 32'd0);
         end
      endcase
   end

   // Every comparison in the bench funnels through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives every field of one requester's channel.
   task automatic applyStimulus(input int idx, input logic valid, input aluop_e op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic itype, input logic [31:0] a,
                                input logic [31:0] b);
      reqValid[idx] = valid;
      reqAluop[idx] = op;
      reqFunct3[idx*3 +: 3] = f3;
      reqFunct7[idx*7 +: 7] = f7;
      reqItype[idx] = itype;
      reqA[idx*32 +: 32] = a;
      reqB[idx*32 +: 32] = b;
   endtask

   task automatic pushExp(input int owner, input logic [31:0] res, input logic zero);
      expT e;
      e.owner = owner;
      e.res = res;
      e.zero = zero;
      sbQ.push_back(e);
   endtask

   // Scoreboard side: every completed response handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (rstN && |(respValid & respReady)) begin
         if (sbQ.size() == 0) begin
            checkOutput("sb_underflow", 32'd0, 32'd1);
         end else begin
            expT e;
            e = sbQ.pop_front();
            checkOutput("sb_owner", {30'd0, respValid}, 32'd1 << e.owner);
            checkOutput("sb_res", respRes, e.res);
            checkOutput("sb_zero", {31'd0, respZero}, {31'd0, e.zero});
         end
      end
   end

   initial begin
      rstN = 1'b0;
      reqValid = '0;
      reqFunct3 = '0;
      reqFunct7 = '0;
      reqItype = '0;
      reqAluop = '{ALUOP_ADD, ALUOP_ADD};
      reqA = '0;
      reqB = '0;
      respReady = 2'b00;
`ifdef ALU_ARB_STALL_CNT_EN
      stallClr = 1'b0;
`endif
      applyStimulus(0, 1'b1, ALUOP_FUNCT, 3'd0, 7'h00, 1'b1, 32'd5, 32'd3);
      applyStimulus(1, 1'b1, ALUOP_FUNCT, 3'd0, 7'h20, 1'b0, 32'd10, 32'd4);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready", {30'd0, reqReady}, 32'd0);
      checkOutput("rst_resp_valid", {30'd0, respValid}, 32'd0);
      checkOutput("rst_resp_res", respRes, 32'd0);
      checkOutput("rst_resp_zero", {31'd0, respZero}, 32'd0);

      @(posedge clk); #1;
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("first_grant", {30'd0, reqReady}, 32'd1);
      pushExp(0, 32'd8, 1'b0);

      @(posedge clk); #1;
      reqValid[0] = 1'b0;
      respReady = 2'b01;
      @(negedge clk);
      checkOutput("single_valid", {30'd0, respValid}, 32'd1);
      checkOutput("single_res", respRes, 32'd8);
      checkOutput("rr_to_req1", {30'd0, reqReady}, 32'd2);
      pushExp(1, 32'd6, 1'b0);

      @(posedge clk); #1;
      reqValid[1] = 1'b0;
      respReady = 2'b00;
      applyStimulus(0, 1'b1, ALUOP_FUNCT, 3'd7, 7'h00, 1'b0, 32'hF0, 32'h3C);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("bp_valid", {30'd0, respValid}, 32'd2);
         checkOutput("bp_res", respRes, 32'd6);
         checkOutput("bp_req_ready", {30'd0, reqReady}, 32'd0);
      end

      @(posedge clk); #1;
      respReady = 2'b10;
      @(negedge clk);
      checkOutput("bp_release_valid", {30'd0, respValid}, 32'd2);
      checkOutput("accept_with_fire", {30'd0, reqReady}, 32'd1);
      pushExp(0, 32'h30, 1'b0);

      @(posedge clk); #1;
      reqValid[0] = 1'b0;
      respReady = 2'b11;
      applyStimulus(1, 1'b1, ALUOP_BRANCH, 3'd0, 7'h00, 1'b0, 32'd7, 32'd7);
      @(negedge clk);
      checkOutput("and_valid", {30'd0, respValid}, 32'd1);
      checkOutput("and_res", respRes, 32'h30);
      checkOutput("beq_ready", {30'd0, reqReady}, 32'd2);
      pushExp(1, 32'd0, 1'b1);

      @(posedge clk); #1;
      applyStimulus(1, 1'b1, ALUOP_BRANCH, 3'd4, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd0);
      @(negedge clk);
      checkOutput("beq_zero", {31'd0, respZero}, 32'd1);
      checkOutput("blt_ready", {30'd0, reqReady}, 32'd2);
      pushExp(1, 32'hFFFF_FFFF, 1'b1);

      @(posedge clk); #1;
      aVal[0] = 32'd100;
      bVal[0] = 32'd1;
      aVal[1] = 32'd200;
      bVal[1] = 32'd2;
      applyStimulus(0, 1'b1, ALUOP_FUNCT, 3'd0, 7'h00, 1'b1, aVal[0], bVal[0]);
      applyStimulus(1, 1'b1, ALUOP_FUNCT, 3'd0, 7'h00, 1'b1, aVal[1], bVal[1]);
      for (int k = 0; k < 4; k++) begin
         int g;
         g = k % 2;
         @(negedge clk);
         checkOutput("fair_grant", {30'd0, reqReady}, 32'd1 << g);
         checkOutput("fair_owner", {30'd0, respValid}, 32'd1 << (1 - g));
         pushExp(g, aVal[g] + bVal[g], 1'b0);
         @(posedge clk); #1;
         aVal[g] = aVal[g] + 32'd7;
         bVal[g] = bVal[g] + 32'd3;
         applyStimulus(g, 1'b1, ALUOP_FUNCT, 3'd0, 7'h00, 1'b1, aVal[g], bVal[g]);
      end
      reqValid = 2'b00;
      @(negedge clk);
      checkOutput("drain_valid", {30'd0, respValid}, 32'd2);
      checkOutput("drain_ready", {30'd0, reqReady}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("idle_valid", {30'd0, respValid}, 32'd0);

      @(posedge clk); #1;
      respReady = 2'b00;
      applyStimulus(1, 1'b1, ALUOP_FUNCT, 3'd6, 7'h00, 1'b0, 32'h0F, 32'hF0);
      @(negedge clk);
      checkOutput("pre_rst_accept", {30'd0, reqReady}, 32'd2);
      @(posedge clk); #1;
      reqValid[1] = 1'b0;
      @(negedge clk);
      checkOutput("full_before_rst", {30'd0, respValid}, 32'd2);
      checkOutput("full_res", respRes, 32'hFF);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("async_clear_valid", {30'd0, respValid}, 32'd0);
      checkOutput("async_clear_res", respRes, 32'd0);
      checkOutput("async_req_ready", {30'd0, reqReady}, 32'd0);

      @(posedge clk); #1;
      rstN = 1'b1;
      reqValid = 2'b11;
      @(negedge clk);
      checkOutput("ptr_after_rst", {30'd0, reqReady}, 32'd1);
      checkOutput("sb_drained", sbQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single integer ALU between NumReq requesters, e.g. the execute-stage ALU op and the branch-compare unit. Arbitration is round-robin. Each requester uses a valid/ready request channel and a valid/ready response channel. The ALU is driven combinationally from the granted request. Its result and zero flag are captured into a one-entry response register, so latency is 1 cycle from accept to response.

Parameters:
NumReq, 2, number of requesters (>=2)
RespIdW, $clog2(NumReq), width of the owner index (internal)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NumReq  request valid per requester
req_ready_o  out  NumReq  request accepted per requester
req_funct3_i  in  NumReq*3  packed funct3 per requester
req_funct7_i  in  NumReq*7  packed funct7 per requester
req_itype_i  in  NumReq  I-type flag per requester
req_aluop_i  in  NumReq x aluop_e  packed ALU op per requester
req_a_i  in  NumReq*Xlen  packed operand A
req_b_i  in  NumReq*Xlen  packed operand B
alu_funct3_o  out  3  to ALU
alu_funct7_o  out  7  to ALU
alu_itype_o  out  1  to ALU
alu_aluop_o  out  aluop_e  to ALU
alu_a_o  out  Xlen  to ALU
alu_b_o  out  Xlen  to ALU
alu_res_i  in  Xlen  from ALU
alu_zero_i  in  1  from ALU
resp_valid_o  out  NumReq  one-hot response valid to the owning requester
resp_ready_i  in  NumReq  response ready per requester
resp_res_o  out  Xlen  registered result, shared by all requesters
resp_zero_o  out  1  registered zero/branch flag, shared

Behaviour:
- Reset (async, rst_ni=0):
  - resp_valid_o=0; resp_res_o=0; resp_zero_o=0.
  - Round-robin pointer=0.
  - Owner index=0. req_ready_o=0 while in reset.
- Response register states:
  - EMPTY: no response held.
  - FULL: holding a response for the owner.
  - resp_fire = resp_valid_o[owner] & resp_ready_i[owner].
  - can_accept = EMPTY | resp_fire.
- Grant (combinational):
  - Consider only requesters with req_valid_i=1.
  - Search starts at the pointer and wraps modulo NumReq.
  - Exactly one grant, or none.
- Request handshake:
  - req_ready_o[g] = grant[g] & can_accept. All other bits are 0.
  - Accept = valid & ready.
- ALU drive:
  - alu_* = fields of the granted requester.
  - With no grant, alu_* = fields of requester 0. Value don't-care; it must not be captured.
- On accept (rising edge):
  - Capture alu_res_i into resp_res_o and alu_zero_i into resp_zero_o.
  - Owner <= g. State becomes FULL. Pointer <= (g+1) mod NumReq.
- resp_valid_o = one-hot(owner) when FULL, else 0.
- resp_fire without a new accept: state becomes EMPTY. resp_res_o and resp_zero_o hold their last values.
- Simultaneous resp_fire and accept in the same cycle: new response replaces the old. State stays FULL. Back-to-back throughput is 1 op/cycle.
- Backpressure: FULL with resp_ready_i[owner]=0:
  - All req_ready_o=0.
  - resp_res_o, resp_zero_o and owner are stable. Pointer is unchanged.
- Requester obligation: hold all req fields stable while valid & !ready. The block does not check this.
- resp_ready_i bits of non-owners are ignored.
- Pointer changes only on accept, so an idle cycle does not change fairness.
- Reset mid-operation: any held response is discarded immediately, asynchronously.

Optional Feature:
ALU_ARB_STALL_CNT_EN
- Defined: adds output stall_cnt_o[31:0], reset to 0.
  - Increments by 1 each cycle in which any req_valid_i=1 and no accept occurs.
  - Wraps at 2^32.
  - Synchronous clear input stall_clr_i has priority over increment.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
1. Reset: rst_ni=0 for 3 cycles with req_valid_i=2'b11 -> req_ready_o=0, resp_valid_o=0, resp_res_o=0. After release, first grant goes to requester 0.
2. Single op: req0 aluop=Funct, funct3=0, itype=1, a=5, b=3 -> req_ready_o=01 same cycle. Next cycle resp_valid_o=01, resp_res_o=8. resp_ready_i=01 clears resp_valid_o.
3. Fairness: both valid continuously, resp_ready_i=11 -> accepts alternate 0,1,0,1 on consecutive cycles; resp_valid_o one-hot tracks the owner each cycle.
4. Backpressure: req1 sub a=10, b=4 accepted; resp_ready_i[1]=0 for 3 cycles -> resp_res_o=6 held, req_ready_o=00 throughout. Release -> req0 accepted in the same cycle as resp_fire.
5. Branch flag: req1 funct3=0, a=b=7 -> resp_zero_o=1. funct3=4, a=-1, b=0 -> resp_zero_o=1 (blt taken).
6. Async reset while FULL (resp_valid_o=10) -> resp_valid_o=0 immediately without a clock edge; pointer returns to 0.
